seq_detect_scheduler: RTL and testbench
=======================================

Name: seq_detect_scheduler

Overview:
- Time-shares one bit-serial Mealy pattern detector across N_CH serial input channels.
- Per-channel detector context (bit history plus fill count) is saved and restored, so each channel sees an independent detector.
- A round-robin arbiter grants at most one channel bit per cycle.
- Sits between the serial front-ends and the event logger; replaces per-channel detector instances.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- PAT_LEN, 4, pattern length in bits (2..8).
- PATTERN, 4'b1101, target sequence; MSB is the first bit received.
- CH_W, clog2(N_CH) (derived, localparam), channel index width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  N_CH  channel i has a bit pending; held until granted
- din  in  N_CH  bit offered by channel i; valid while req[i]
- clr  in  N_CH  synchronous per-channel context clear
- gnt  out  N_CH  one-hot grant, combinational from req and pointer
- dout_valid  out  1  registered; a granted bit was processed last cycle
- dout_chan  out  CH_W  registered; channel of that bit
- dout  out  1  registered; pattern completed on that bit

Behaviour:
- Reset, asynchronous active-high:
  - all contexts: hist=0, fill=0
  - rr pointer = 0
  - dout_valid=0, dout_chan=0, dout=0
  - gnt=0 while reset is high
- Arbitration:
  - Search req starting at the pointer, ascending, wrapping past N_CH-1 to 0. The first set bit wins.
  - gnt is one-hot or zero. A requester sees gnt[i]=1 in the cycle it is consumed and may change req/din on the next cycle.
  - Pointer moves to winner+1 (mod N_CH) only on a grant; otherwise it holds.
- Context per channel:
  - hist: PAT_LEN-1 bits, last bits received, newest in the LSB.
  - fill: 0..PAT_LEN-1, saturating.
- Step for granted channel c with bit b:
  - match = (fill == PAT_LEN-1) && ({hist,b} == PATTERN)
  - hist <= {hist[PAT_LEN-3:0], b}
  - fill <= min(fill+1, PAT_LEN-1)
- Output timing:
  - At the edge ending grant cycle t: dout_valid=1, dout_chan=c, dout=match.
  - Latency is 1 cycle.
  - With no grant: dout_valid=0, dout=0, dout_chan holds its last value.
- clr[i]: the context of channel i is zeroed at the next edge.
  - Clear on a non-granted channel does not disturb the grant or step of other channels.
  - Clear and grant on the same channel in the same cycle:
    - grant still issued and bit consumed
    - clear wins: context zeroed
    - dout_valid=1, dout=0
- Idle, all req=0: contexts and pointer unchanged.
- Reset asserted mid-stream: partial matches are lost and the next bits restart from fill=0.

Optional Feature:
- Macro SEQ_OVERLAP_EN.
- Defined: on match, context updates normally, so overlapping matches are found. Per-channel stream 1101101 gives hits on bits 4 and 7.
- Undefined: on match, context forced to hist=0, fill=0 (non-overlap). Stream 1101101 gives a hit on bit 4 only.

Decomposition:
- Package seq_sched_pkg holds:
  - clog2 function for CH_W
  - default PATTERN/PAT_LEN constants
  - context field widths
- Sub-module seq_match_step (combinational): inputs hist, fill, b; outputs next_hist, next_fill, match. Implements the step and the SEQ_OVERLAP_EN choice.
- Top module holds:
  - context register arrays
  - round-robin arbiter
  - output registers

Test Plan:
- Single channel 0, req held high, din stream 1,1,0,1,1,0,1 -> dout_valid=1 for 7 consecutive cycles, dout_chan=0.
  - With SEQ_OVERLAP_EN: dout=1 on outputs 4 and 7.
  - Without SEQ_OVERLAP_EN: dout=1 on output 4 only.
- All 4 req high continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Each channel fed 1101 in its own slots -> dout=1 with dout_chan 0,1,2,3 in cycles 13..16 after start.
- Interleave: ch1 sends 1,1,0 then ch2 sends 1 then ch1 sends 1 -> no hit on ch2; dout=1 with dout_chan=1 (contexts independent).
- clr[0] asserted in the same cycle ch0 is granted bit 1 of a stream 1,1,0 already at fill=3 -> dout=0; next bits 1,1,0 -> no hit until the 4th bit after the clear.
- Async reset pulse mid-cycle after ch3 has received 110 -> outputs 0 immediately; pointer 0; next ch3 bit 1 -> dout=0.
- req=0 for 5 cycles -> dout_valid=0, gnt=0; pointer unchanged, verified by next grant order.

Source files
------------

// File: rtl/seq_detect_scheduler_pkg.sv
// Shared constants and helpers for the time-shared sequence detector.
// Default pattern/length and context field widths live here.
package seq_sched_pkg;

  localparam int unsigned DefPatLen = 4;
  localparam logic [DefPatLen-1:0] DefPattern = 4'b1101;

  // Fill never exceeds PAT_LEN-1 <= 7, so three bits cover every legal PAT_LEN.
  localparam int unsigned FillW = 3;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_match_step.sv
// One combinational step of the Mealy pattern detector on a saved context.
// SEQ_OVERLAP_EN defined keeps the context after a hit; otherwise it is zeroed.
module seq_match_step
  import seq_sched_pkg::*;
#(
  parameter int unsigned          PAT_LEN = DefPatLen,
  parameter logic [PAT_LEN-1:0]   PATTERN = DefPattern
) (
  input  logic [PAT_LEN-2:0] i_hist,
  input  logic [FillW-1:0]   i_fill,
  input  logic               i_b,
  output logic [PAT_LEN-2:0] o_next_hist,
  output logic [FillW-1:0]   o_next_fill,
  output logic               o_match
);

  localparam logic [FillW-1:0] FillMax = FillW'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] w_window;

  assign w_window = {i_hist, i_b};
  assign o_match  = (i_fill == FillMax) && (w_window == PATTERN);

  always_comb begin
    o_next_hist = w_window[PAT_LEN-2:0];
    o_next_fill = (i_fill == FillMax) ? FillMax : i_fill + 1'b1;
`ifdef SEQ_OVERLAP_EN
`else
    if (o_match) begin
      o_next_hist = '0;
      o_next_fill = '0;
    end
`endif
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin time-sharing of one bit-serial pattern detector over N_CH channels.
// Overlapping-match behaviour selected by macro SEQ_OVERLAP_EN (see seq_match_step).
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int unsigned        N_CH    = 4,
  parameter int unsigned        PAT_LEN = DefPatLen,
  parameter logic [PAT_LEN-1:0] PATTERN = DefPattern,
  localparam int unsigned       CH_W    = (N_CH > 1) ? clog2(N_CH) : 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N_CH-1:0] i_req,
  input  logic [N_CH-1:0] i_din,
  input  logic [N_CH-1:0] i_clr,
  output logic [N_CH-1:0] o_gnt,
  output logic            o_dout_valid,
  output logic [CH_W-1:0] o_dout_chan,
  output logic            o_dout
);

  localparam int unsigned HistW = PAT_LEN - 1;

  logic [HistW-1:0] r_hist [N_CH];
  logic [FillW-1:0] r_fill [N_CH];
  logic [CH_W-1:0]  r_ptr;
  logic             r_dout_valid;
  logic [CH_W-1:0]  r_dout_chan;
  logic             r_dout;

  logic             w_any;
  logic [CH_W-1:0]  w_win;
  logic [CH_W-1:0]  w_idx;
  logic [CH_W-1:0]  w_ptr_next;
  logic [N_CH-1:0]  w_gnt;
  logic [HistW-1:0] w_next_hist;
  logic [FillW-1:0] w_next_fill;
  logic             w_match;

  // Ascending search from the pointer with wrap; first requester wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    w_gnt = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_idx = CH_W'((32'(r_ptr) + k) % N_CH);
      if (!w_any && i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    if (i_reset) w_any = 1'b0;
    if (w_any) w_gnt[w_win] = 1'b1;
  end

  assign w_ptr_next = (w_win == CH_W'(N_CH - 1)) ? '0 : w_win + 1'b1;

  seq_match_step #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_step (
    .i_hist      (r_hist[w_win]),
    .i_fill      (r_fill[w_win]),
    .i_b         (i_din[w_win]),
    .o_next_hist (w_next_hist),
    .o_next_fill (w_next_fill),
    .o_match     (w_match)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_hist[i] <= '0;
        r_fill[i] <= '0;
      end
      r_ptr        <= '0;
      r_dout_valid <= 1'b0;
      r_dout_chan  <= '0;
      r_dout       <= 1'b0;
    end else begin
      // A clear beats the step when both hit the same channel.
      for (int i = 0; i < N_CH; i++) begin
        if (i_clr[i]) begin
          r_hist[i] <= '0;
          r_fill[i] <= '0;
        end else if (w_any && (w_win == CH_W'(i))) begin
          r_hist[i] <= w_next_hist;
          r_fill[i] <= w_next_fill;
        end
      end
      if (w_any) begin
        r_ptr       <= w_ptr_next;
        r_dout_chan <= w_win;
      end
      r_dout_valid <= w_any;
      r_dout       <= w_any && w_match && !i_clr[w_win];
    end
  end

  assign o_gnt        = w_gnt;
  assign o_dout_valid = r_dout_valid;
  assign o_dout_chan  = r_dout_chan;
  assign o_dout       = r_dout;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboarded bench for seq_detect_scheduler (4 channels, pattern 1101).
// Expected hits follow SEQ_OVERLAP_EN when the macro is defined for the build.
module tb_seq_detect_scheduler;

  typedef struct packed {
    logic       valid;
    logic [1:0] chan;
    logic       dout;
  } exp_t;

  logic       i_clk;
  logic       i_reset;
  logic [3:0] i_req;
  logic [3:0] i_din;
  logic [3:0] i_clr;
  logic [3:0] o_gnt;
  logic       o_dout_valid;
  logic [1:0] o_dout_chan;
  logic       o_dout;

  int         checks;
  int         failures;
  exp_t       sb[$];
  logic [1:0] last_chan;

  // Reference model: full bit string per channel since last clear/hit.
  logic [31:0] m_bits [4];
  int          m_cnt  [4];

  seq_detect_scheduler u_dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req        (i_req),
    .i_din        (i_din),
    .i_clr        (i_clr),
    .o_gnt        (o_gnt),
    .o_dout_valid (o_dout_valid),
    .o_dout_chan  (o_dout_chan),
    .o_dout       (o_dout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic void model_clear(input int c);
    m_bits[c] = '0;
    m_cnt[c]  = 0;
  endfunction

  function automatic logic model_step(input int c, input logic b);
    logic hit;
    m_bits[c] = {m_bits[c][30:0], b};
    m_cnt[c]  = m_cnt[c] + 1;
    hit = (m_cnt[c] >= 4) && (m_bits[c][3:0] == 4'b1101);
`ifndef SEQ_OVERLAP_EN
    if (hit) model_clear(c);
`endif
    return hit;
  endfunction

  // One clocked transaction: drive, check grant, predict, clock, pop and compare.
  task automatic step(input logic [3:0] req, input logic [3:0] din, input logic [3:0] clr,
                      input logic [3:0] exp_gnt, input string name, output logic obs);
    exp_t e;
    i_req = req;
    i_din = din;
    i_clr = clr;
    #1;
    checks++;
    if (o_gnt !== exp_gnt) begin
      failures++;
      $display("FAIL %s gnt: got %b want %b", name, o_gnt, exp_gnt);
    end
    e = '0;
    for (int c = 0; c < 4; c++) begin
      if (exp_gnt[c]) begin
        e.valid = 1'b1;
        e.chan  = 2'(c);
        e.dout  = model_step(c, din[c]) && !clr[c];
      end
    end
    for (int c = 0; c < 4; c++) if (clr[c]) model_clear(c);
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (o_dout_valid !== e.valid || o_dout !== e.dout) begin
      failures++;
      $display("FAIL %s valid/dout: got %b/%b want %b/%b", name, o_dout_valid, o_dout,
               e.valid, e.dout);
    end
    if (e.valid) last_chan = e.chan;
    checks++;
    if (o_dout_chan !== last_chan) begin
      failures++;
      $display("FAIL %s chan: got %0d want %0d", name, o_dout_chan, last_chan);
    end
    obs = o_dout;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_req   = 4'hF;
    i_clr   = '0;
    i_din   = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_gnt !== 4'b0 || o_dout_valid !== 1'b0 || o_dout !== 1'b0 || o_dout_chan !== 2'd0) begin
      failures++;
      $display("FAIL reset: got gnt=%b v=%b d=%b ch=%0d want all zero", o_gnt, o_dout_valid,
               o_dout, o_dout_chan);
    end
    i_reset = 1'b0;
    i_req   = '0;
    for (int c = 0; c < 4; c++) model_clear(c);
    last_chan = '0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single();
    logic [6:0] stream;
    logic [6:0] hits;
    logic [6:0] want;
    logic       obs;
    do_reset();
    stream = 7'b1101101;
    hits   = '0;
`ifdef SEQ_OVERLAP_EN
    want = 7'b0001001;
`else
    want = 7'b0001000;
`endif
    for (int k = 0; k < 7; k++) begin
      step(4'b0001, {3'b0, stream[6-k]}, 4'b0, 4'b0001, "single", obs);
      hits[6-k] = obs;
    end
    checks++;
    if (hits !== want) begin
      failures++;
      $display("FAIL single_hits: got %b want %b", hits, want);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] pat;
    logic       obs;
    logic       b;
    int         nhits;
    do_reset();
    pat   = 4'b1101;
    nhits = 0;
    for (int k = 0; k < 16; k++) begin
      b = pat[3 - k/4];
      step(4'hF, {4{b}}, 4'b0, 4'b0001 << (k % 4), "rr", obs);
      if (obs) nhits++;
    end
    step(4'hF, 4'hF, 4'b0, 4'b0001, "rr_wrap", obs);
    checks++;
    if (nhits != 4) begin
      failures++;
      $display("FAIL rr_hits: got %0d want 4", nhits);
    end
  endtask

  task automatic test_interleave();
    logic obs;
    do_reset();
    step(4'b0010, 4'b0010, 4'b0, 4'b0010, "il_ch1_b0", obs);
    step(4'b0010, 4'b0010, 4'b0, 4'b0010, "il_ch1_b1", obs);
    step(4'b0010, 4'b0000, 4'b0, 4'b0010, "il_ch1_b2", obs);
    step(4'b0100, 4'b0100, 4'b0, 4'b0100, "il_ch2", obs);
    step(4'b0010, 4'b0010, 4'b0100, 4'b0010, "il_ch1_b3", obs);
    checks++;
    if (obs !== 1'b1) begin
      failures++;
      $display("FAIL il_hit: got %b want 1", obs);
    end
  endtask

  task automatic test_clear();
    logic obs;
    logic [2:0] pre;
    do_reset();
    pre = 3'b110;
    for (int k = 0; k < 3; k++) step(4'b0001, {3'b0, pre[2-k]}, 4'b0, 4'b0001, "clr_pre", obs);
    step(4'b0001, 4'b0001, 4'b0001, 4'b0001, "clr_same", obs);
    for (int k = 0; k < 3; k++) step(4'b0001, {3'b0, pre[2-k]}, 4'b0, 4'b0001, "clr_post", obs);
    step(4'b0001, 4'b0001, 4'b0, 4'b0001, "clr_fourth", obs);
    checks++;
    if (obs !== 1'b1) begin
      failures++;
      $display("FAIL clr_fourth_hit: got %b want 1", obs);
    end
  endtask

  task automatic test_async_reset();
    logic obs;
    logic [2:0] pre;
    do_reset();
    pre = 3'b110;
    for (int k = 0; k < 3; k++) step(4'b1000, {pre[2-k], 3'b0}, 4'b0, 4'b1000, "ar_ch3", obs);
    step(4'b0010, 4'b0000, 4'b0, 4'b0010, "ar_ch1", obs);
    i_req = 4'b0010;
    #3;
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_dout_valid !== 1'b0 || o_dout_chan !== 2'd0 || o_gnt !== 4'b0) begin
      failures++;
      $display("FAIL ar_immediate: got v=%b ch=%0d gnt=%b want 0/0/0", o_dout_valid,
               o_dout_chan, o_gnt);
    end
    i_req = '0;
    #1;
    i_reset = 1'b0;
    for (int c = 0; c < 4; c++) model_clear(c);
    last_chan = '0;
    @(posedge i_clk);
    #1;
    step(4'b1011, 4'b0000, 4'b0, 4'b0001, "ar_ptr0", obs);
    step(4'b1000, 4'b1000, 4'b0, 4'b1000, "ar_ch3_after", obs);
  endtask

  task automatic test_idle();
    logic obs;
    step(4'b0010, 4'b0000, 4'b0, 4'b0010, "idle_pre", obs);
    for (int k = 0; k < 5; k++) step(4'b0000, 4'b0000, 4'b0, 4'b0000, "idle", obs);
    step(4'hF, 4'h0, 4'b0, 4'b0100, "idle_rr0", obs);
    step(4'hF, 4'h0, 4'b0, 4'b1000, "idle_rr1", obs);
    step(4'hF, 4'h0, 4'b0, 4'b0001, "idle_rr2", obs);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    i_reset   = 1'b1;
    i_req     = '0;
    i_din     = '0;
    i_clr     = '0;
    last_chan = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_interleave();
    test_clear();
    test_async_reset();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
